div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: rst falling clears state immediately, independent of clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 enable  input  1  high = run; low = synchronous abort to IDLE.
REQ-005 start  input  1  request pulse; operation begins on its falling edge.
REQ-006 inbus  input  8  operand bus: dividend, then divisor, on consecutive cycles.
REQ-007 outbus  output  8  result bus: quotient, then remainder.
REQ-008 out_valid  output  1  high while outbus carries a result byte.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 div_zero  output  1  sticky flag, divisor was 0; cleared at next operand load.

Function
REQ-011 The block SHALL perform unsigned 8-bit / 8-bit restoring division.
  - 9-bit partial remainder A.
  - 8-bit quotient/dividend register Q.
  - 8-bit divisor M.
  - 3-bit iteration counter.
REQ-012 States SHALL be IDLE, WAIT_FALL, LOAD_M, SHIFT, SUB, OUT_Q, OUT_R.
REQ-013 IDLE: start=1 -> WAIT_FALL; otherwise stay.
REQ-014 WAIT_FALL: start=1 -> stay, for any number of cycles.
  - start=0 -> LOAD_M, with Q<=inbus, A<=0, counter<=0, div_zero<=0.
REQ-015 LOAD_M: M<=inbus.
  - inbus!=0 -> SHIFT.
  - inbus==0 -> OUT_Q, with div_zero<=1, Q<=8'hFF, A<=dividend.
REQ-016 SHIFT: {A,Q} SHALL shift left one bit, Q[0]<=0; -> SUB.
REQ-017 SUB: compute D=A-{0,M}.
  - D[8]==0: A<=D, Q[0]<=1.
  - D[8]==1: A unchanged.
  - counter==7 -> OUT_Q; otherwise counter+1 and -> SHIFT.
REQ-018 OUT_Q: outbus=Q, out_valid=1; -> OUT_R.
REQ-019 OUT_R: outbus=A[7:0], out_valid=1; -> IDLE.
REQ-020 Outside OUT_Q/OUT_R, out_valid SHALL be 0 and outbus SHALL hold its last value.
REQ-021 Latency SHALL be fixed, with E0 = the edge at which the dividend is captured:
  - Nonzero divisor: out_valid high in the cycles after E17 (quotient) and E18 (remainder); IDLE after E19.
  - Zero divisor: quotient after E1, remainder after E2.
REQ-022 start rising during any non-IDLE state SHALL be ignored; a new request needs ready=1 first.
REQ-023 enable=0 in any state SHALL force IDLE at the next edge, with out_valid=0.
  - A, Q, M, div_zero hold their values.
  - The aborted operation produces no output.
REQ-024 enable=0 SHALL override all other transitions in the same cycle.
REQ-025 ready SHALL be decoded combinationally from state; outbus and out_valid SHALL be registered or state-decoded, glitch-free.

Reset
REQ-026 rst=0 SHALL force, asynchronously:
  - state=IDLE.
  - A=0, Q=0, M=0, counter=0.
  - outbus=0, out_valid=0, div_zero=0, ready=1.
REQ-027 Reset mid-operation SHALL discard the operation with no partial output.
  - After release, the block waits for a fresh start pulse.

Structure
REQ-028 Package div_pkg SHALL hold:
  - the state enumeration (4-bit encoding; IDLE=0).
  - the data width constant (8).
  - the iteration count constant (8).
REQ-029 Sub-module div_datapath SHALL hold A/Q/M registers, the 9-bit subtractor and the counter, driven by one-hot control strobes.
  - The FSM stays in div_seq.
REQ-030 The RTL SHALL total 120-400 lines.

Verification
REQ-031 100/7: dividend 8'd100, divisor 8'd7 -> quotient 8'h0E at E17+, remainder 8'h02 next cycle, div_zero=0.
REQ-032 255/1 and 5/9:
  - 255/1 -> quotient 8'hFF, remainder 8'h00.
  - 5/9 -> quotient 8'h00, remainder 8'h05.
REQ-033 Divide by zero: dividend 8'h40, divisor 0 -> div_zero=1, quotient 8'hFF, remainder 8'h40, IDLE three edges after E0.
REQ-034 Held start: start high 10 cycles, then low -> dividend captured on first low-sampled edge; ready=0 throughout.
REQ-035 Abort:
  - enable low at SUB of iteration 4 -> IDLE next edge, no out_valid pulse.
  - Separately, rst low mid-SHIFT -> all outputs at reset values immediately.
  - A following 200/10 -> quotient 8'h14, remainder 8'h00.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    localparam int DATA_W = 8;
    localparam int ITER_N = 8;
    localparam int CNT_W  = $clog2(ITER_N);

    // Controller states; IDLE must stay at zero so a cleared state register means idle.
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WAIT_FALL = 4'd1,
        LOAD_M    = 4'd2,
        SHIFT     = 4'd3,
        SUB       = 4'd4,
        OUT_Q     = 4'd5,
        OUT_R     = 4'd6
    } state_e;

    // One-hot datapath strobes issued by the controller; all-zero means hold.
    typedef struct packed {
        logic ld_dvd;   // capture dividend into Q, clear A/counter/div_zero
        logic ld_dvs;   // capture divisor into M (handles the zero case)
        logic shift;    // shift {A,Q} left by one
        logic sub;      // trial subtract and restore
        logic out_r;    // present remainder on outbus
    } ctrl_t;

endpackage

// File: rtl/div_if.sv
// Operand/result bundle between requester and divider.
// Latency: n/a (wires only).
// Backpressure: none; requester must wait for ready before pulsing start.
interface div_if;
    import div_pkg::*;

    logic              enable;
    logic              start;
    logic [DATA_W-1:0] inbus;
    logic [DATA_W-1:0] outbus;
    logic              out_valid;
    logic              ready;
    logic              div_zero;

    modport master (
        output enable, start, inbus,
        input  outbus, out_valid, ready, div_zero
    );

    modport slave (
        input  enable, start, inbus,
        output outbus, out_valid, ready, div_zero
    );

endinterface

// File: rtl/div_datapath.sv
// A/Q/M registers, 9-bit trial subtractor, iteration counter and result register.
// Latency: every strobe takes effect at the next clock edge.
// Backpressure: none; registers hold whenever no strobe is active.
module div_datapath
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  ctrl_t             ctrl,
    input  logic [DATA_W-1:0] inbus,
    output logic              last_iter,
    output logic              dvs_zero,
    output logic [DATA_W-1:0] outbus,
    output logic              div_zero
);

    logic [DATA_W:0]   a_q, a_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dz_q, dz_d;
    logic [DATA_W-1:0] ob_q, ob_d;
    logic [DATA_W:0]   diff;

    assign last_iter = (cnt_q == CNT_W'(ITER_N - 1));
    assign dvs_zero  = (inbus == '0);
    assign outbus    = ob_q;
    assign div_zero  = dz_q;

    // Next-value logic for all datapath registers, selected by the active strobe.
    always_comb begin
        diff  = a_q - {1'b0, m_q};
        a_d   = a_q;
        q_d   = q_q;
        m_d   = m_q;
        cnt_d = cnt_q;
        dz_d  = dz_q;
        ob_d  = ob_q;
        if (ctrl.ld_dvd) begin
            q_d   = inbus;
            a_d   = '0;
            cnt_d = '0;
            dz_d  = 1'b0;
        end else if (ctrl.ld_dvs) begin
            m_d = inbus;
            if (dvs_zero) begin
                // Divide by zero: saturated quotient, dividend passed through as remainder.
                dz_d = 1'b1;
                q_d  = '1;
                a_d  = {1'b0, q_q};
                ob_d = '1;
            end
        end else if (ctrl.shift) begin
            a_d = {a_q[DATA_W-1:0], q_q[DATA_W-1]};
            q_d = {q_q[DATA_W-2:0], 1'b0};
        end else if (ctrl.sub) begin
            // Sign bit clear means A >= M: keep the difference and set the quotient bit.
            if (!diff[DATA_W]) begin
                a_d    = diff;
                q_d[0] = 1'b1;
            end
            // Final quotient goes straight into the result register so it is
            // registered on the same edge the controller enters OUT_Q.
            if (last_iter) begin
                ob_d = q_d;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (ctrl.out_r) begin
            ob_d = a_q[DATA_W-1:0];
        end
    end

    // Datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            q_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
            dz_q  <= 1'b0;
            ob_q  <= '0;
        end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
            dz_q  <= dz_d;
            ob_q  <= ob_d;
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned 8/8 restoring divider: controller FSM around div_datapath.
// Latency: quotient 17 cycles after dividend capture (1 for divide-by-zero), remainder next cycle.
// Backpressure: none; new requests accepted only while ready, enable low aborts to IDLE.
module div_seq
    import div_pkg::*;
(
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    state_e state_q, state_d;
    logic   out_valid_q, out_valid_d;
    ctrl_t  ctrl;
    logic   last_iter;
    logic   dvs_zero;

    div_datapath u_datapath (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (ctrl),
        .inbus     (bus.inbus),
        .last_iter (last_iter),
        .dvs_zero  (dvs_zero),
        .outbus    (bus.outbus),
        .div_zero  (bus.div_zero)
    );

    assign bus.ready     = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;

    // State register and registered result-valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state decode; enable low overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (bus.start)  state_d = WAIT_FALL;
                WAIT_FALL: if (!bus.start) state_d = LOAD_M;
                LOAD_M:    state_d = dvs_zero ? OUT_Q : SHIFT;
                SHIFT:     state_d = SUB;
                SUB:       state_d = last_iter ? OUT_Q : SHIFT;
                OUT_Q:     state_d = OUT_R;
                OUT_R:     state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Datapath strobes and the next value of out_valid.
    always_comb begin
        ctrl        = '0;
        out_valid_d = (state_d == OUT_Q) || (state_d == OUT_R);
        if (bus.enable) begin
            case (state_q)
                WAIT_FALL: ctrl.ld_dvd = !bus.start;
                LOAD_M:    ctrl.ld_dvs = 1'b1;
                SHIFT:     ctrl.shift  = 1'b1;
                SUB:       ctrl.sub    = 1'b1;
                OUT_Q:     ctrl.out_r  = 1'b1;
                default:   ctrl        = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table, hand sequences, random ops vs. / and %.
// Latency: checks exact quotient/remainder cycle positions.
// Backpressure: waits (bounded) for ready before each request.
module tb_div_seq;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_if u_if ();

    div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (u_if.ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready_before_start"}, int'(u_if.ready), 1);
    endtask

    // Pulse start for 'hold' cycles, then present dividend and divisor on consecutive cycles.
    task automatic start_op(input logic [7:0] dvd, input logic [7:0] dvs,
                            input int hold, input string tag);
        @(negedge clk);
        u_if.start = 1'b1;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chk($sformatf("%s ready_low_held_%0d", tag, i), int'(u_if.ready), 0);
        end
        @(negedge clk);
        u_if.start = 1'b0;
        u_if.inbus = dvd;
        @(negedge clk);
        u_if.inbus = dvs;
    endtask

    task automatic run_op(input logic [7:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez,
                          input int hold, input string tag);
        int k;
        int lat;
        bit found;
        lat = (dvs == 8'd0) ? 1 : 17;
        wait_ready(tag);
        start_op(dvd, dvs, hold, tag);
        k = 0;
        found = 1'b0;
        while (k < 40 && !found) begin
            @(negedge clk);
            k++;
            if (k == 5) chk({tag, " ready_busy"}, int'(u_if.ready), 0);
            // A start pulse mid-operation must be ignored.
            if (k == 4) u_if.start = 1'b1;
            if (k == 5) u_if.start = 1'b0;
            if (u_if.out_valid === 1'b1) found = 1'b1;
        end
        u_if.start = 1'b0;
        chk({tag, " latency"}, k, lat);
        chk({tag, " quotient"}, int'(u_if.outbus), int'(eq));
        chk({tag, " div_zero"}, int'(u_if.div_zero), int'(ez));
        @(negedge clk);
        chk({tag, " rem_valid"}, int'(u_if.out_valid), 1);
        chk({tag, " remainder"}, int'(u_if.outbus), int'(er));
        @(negedge clk);
        chk({tag, " idle_ready"}, int'(u_if.ready), 1);
        chk({tag, " valid_drop"}, int'(u_if.out_valid), 0);
        chk({tag, " outbus_hold"}, int'(u_if.outbus), int'(er));
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        int seen;
        checks   = 0;
        failures = 0;

        tbl[0] = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0};
        tbl[1] = '{8'd255, 8'd1,   8'hFF, 8'h00, 1'b0};
        tbl[2] = '{8'd5,   8'd9,   8'h00, 8'h05, 1'b0};
        tbl[3] = '{8'h40,  8'd0,   8'hFF, 8'h40, 1'b1};
        tbl[4] = '{8'd200, 8'd10,  8'h14, 8'h00, 1'b0};
        tbl[5] = '{8'd0,   8'd5,   8'h00, 8'h00, 1'b0};
        tbl[6] = '{8'd255, 8'd255, 8'h01, 8'h00, 1'b0};
        tbl[7] = '{8'd254, 8'd16,  8'h0F, 8'h0E, 1'b0};
        tbl[8] = '{8'd0,   8'd0,   8'hFF, 8'h00, 1'b1};

        rst          = 1'b0;
        u_if.enable  = 1'b1;
        u_if.start   = 1'b0;
        u_if.inbus   = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("reset outbus", int'(u_if.outbus), 0);
        chk("reset out_valid", int'(u_if.out_valid), 0);
        chk("reset ready", int'(u_if.ready), 1);
        chk("reset div_zero", int'(u_if.div_zero), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].dvd, tbl[i].dvs, tbl[i].q, tbl[i].r, tbl[i].dz, 1,
                   $sformatf("vec%0d", i));
        end

        // Start held high for ten cycles before falling.
        run_op(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 10, "held_start");

        // Abort with enable low during SUB of iteration 4.
        start_op(8'h5A, 8'd3, 1, "abort");
        for (int i = 0; i < 10; i++) @(negedge clk);
        u_if.enable = 1'b0;
        @(negedge clk);
        chk("abort ready", int'(u_if.ready), 1);
        chk("abort out_valid", int'(u_if.out_valid), 0);
        @(negedge clk);
        @(negedge clk);
        u_if.enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (u_if.out_valid === 1'b1) seen++;
        end
        chk("abort no_output", seen, 0);
        chk("abort outbus_hold", int'(u_if.outbus), 8'h02);
        chk("abort ready_after", int'(u_if.ready), 1);

        // Asynchronous reset in the middle of a SHIFT state.
        start_op(8'h33, 8'd5, 1, "rst_mid");
        for (int i = 0; i < 3; i++) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid outbus", int'(u_if.outbus), 0);
        chk("rst_mid out_valid", int'(u_if.out_valid), 0);
        chk("rst_mid ready", int'(u_if.ready), 1);
        chk("rst_mid div_zero", int'(u_if.div_zero), 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (u_if.out_valid === 1'b1) seen++;
        end
        chk("rst_mid no_output", seen, 0);
        run_op(8'd200, 8'd10, 8'h14, 8'h00, 1'b0, 1, "after_rst");

        // Random operands against plain arithmetic.
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) b = 8'd0;
            if (b == 8'd0)
                run_op(a, b, 8'hFF, a, 1'b1, int'($urandom_range(1, 3)), $sformatf("rnd%0d", i));
            else
                run_op(a, b, a / b, a % b, 1'b0, int'($urandom_range(1, 3)), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
